noc_sim_wrapper: RTL and testbench
==================================

NOC_SIM_WRAPPER -- requirements
Module: noc_sim_wrapper

Interface
REQ-001 Parameter WIDTH, default 32, width of payload words and of out; SHALL be >= 4.
REQ-002 Parameter ERR_INJECT_AT, default 0, sequence number whose payload is corrupted; 0 disables injection.
REQ-003 Compile option DIFF_REFCLK, default undefined; when defined, ref_clk SHALL be replaced by the ref_clk_p/ref_clk_n pair.
REQ-004 ref_clk  input  1  single clock; all logic on its rising edge (DIFF_REFCLK undefined).
REQ-005 ref_clk_p / ref_clk_n  input  1 each  differential clock (DIFF_REFCLK defined); internal clock = ref_clk_p, ref_clk_n unused.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 out  output  WIDTH  status: out[WIDTH-1] = sticky error, out[WIDTH-2:0] = accepted-word count.

Function
REQ-008 Block SHALL contain three stages: traffic generator -> link FIFO -> traffic sink.
REQ-009 Generator SHALL hold seq (WIDTH bits), reset to 1, and present word = seq with valid high every cycle after reset release.
REQ-010 Generator SHALL advance seq by 1 on each accepted push (valid && !full); seq wraps modulo 2^WIDTH.
REQ-011 When ERR_INJECT_AT != 0 and seq == ERR_INJECT_AT, pushed word SHALL be seq with bit 0 inverted; seq still advances normally.
REQ-012 Link FIFO SHALL be 4 entries deep, WIDTH wide, with registered occupancy count (0..4), full = (count == 4), empty = (count == 0).
REQ-013 FIFO push SHALL occur at an edge when valid && !full; a push is blocked when full, even if a pop happens in the same cycle.
REQ-014 FIFO pop SHALL occur at an edge when !empty && sink_ready.
REQ-015 Simultaneous push and pop SHALL leave count unchanged.
REQ-016 Data written at edge N SHALL be poppable at edge N+1 at the earliest; FIFO order SHALL be strict.
REQ-017 Sink SHALL hold a 2-bit bp_cnt that increments every cycle and wraps; sink_ready = (bp_cnt != 3).
REQ-018 Sink SHALL hold expected (WIDTH bits), reset to 1, incremented on each pop.
REQ-019 On each pop, count SHALL increment, saturating at all-ones in WIDTH-1 bits.
REQ-020 On each pop whose data != expected, the error bit SHALL set and SHALL remain set until reset.
REQ-021 out SHALL be driven directly from registers: {error, count}.

Reset
REQ-022 While rst is high, all state SHALL be held at its reset value: seq=1, expected=1, bp_cnt=0, FIFO count=0, error=0, count=0, out=0.
REQ-023 Asserting rst mid-operation SHALL clear all state immediately, without waiting for a clock edge, and discard FIFO contents.
REQ-024 After rst deassertion, traffic SHALL restart with word 1.

Structure
REQ-025 Shared package noc_sim_pkg SHALL hold FIFO_DEPTH=4 and the bp_cnt stall value 3.
REQ-026 FIFO SHALL be a sub-module noc_link_fifo, parameterized by WIDTH and depth, with the same clock and reset.
REQ-027 Generator and sink SHALL be implemented inline in noc_sim_wrapper.

Verification
REQ-028 Release rst, count edges after release -> out = 0 after edge 1, out = 1 after edge 2, out = 3 after edge 5, out = 6 after edge 9.
REQ-029 Run 1000 cycles, defaults -> out[WIDTH-1] = 0; after edge 2, count increases 3 per 4 cycles; FIFO reaches full and the generator stalls.
REQ-030 ERR_INJECT_AT=5 -> out[WIDTH-1] = 1 after the 5th pop and stays 1; count keeps incrementing.
REQ-031 WIDTH=8, run 400 cycles -> out[6:0] saturates at 127, out[7] = 0 (seq wrap does not cause false error).
REQ-032 Assert rst asynchronously mid-run for 3 ns -> out = 0 immediately; after release the REQ-028 sequence repeats.
REQ-033 DIFF_REFCLK defined, drive complementary ref_clk_p/ref_clk_n -> behaviour identical to REQ-028.

Source files
------------

// File: rtl/noc_sim_pkg.sv
// noc_sim_pkg: shared constants for the generator/FIFO/sink link model
package noc_sim_pkg;
  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] BP_STALL = 2'd3;
endpackage

// File: rtl/noc_link_fifo.sv
// noc_link_fifo: registered-count FIFO; push is refused whenever full, regardless of a same-cycle pop
module noc_link_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic wr, rd;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign data_o  = mem_q[rd_q];
  always_comb begin
    wr = push_i & ~full_o;
    rd = pop_i & ~empty_o;
    wr_d = wr ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d = rd ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + AW'(1)) : rd_q;
    count_d = (wr & ~rd) ? count_q + CW'(1) : (rd & ~wr) ? count_q - CW'(1) : count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/noc_sim_wrapper.sv
// noc_sim_wrapper: self-contained traffic generator -> link FIFO -> checking sink, status on out
module noc_sim_wrapper
  import noc_sim_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ERR_INJECT_AT = 0
) (
`ifdef DIFF_REFCLK
  input  logic             ref_clk_p,
  input  logic             ref_clk_n,
`else
  input  logic             ref_clk,
`endif
  input  logic             rst,
  output logic [WIDTH-1:0] out
);
  logic clk;
`ifdef DIFF_REFCLK
  logic unused_ref_n;
  assign clk = ref_clk_p;
  assign unused_ref_n = ref_clk_n;
`else
  assign clk = ref_clk;
`endif
  logic [WIDTH-1:0] seq_q, seq_d, exp_q, exp_d, word, fifo_data;
  logic [WIDTH-2:0] cnt_q, cnt_d;
  logic [1:0] bp_q, bp_d;
  logic err_q, err_d, full, empty, push, pop;
  noc_link_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .data_i(word), .pop_i(pop),
    .data_o(fifo_data), .full_o(full), .empty_o(empty)
  );
  always_comb begin
    push = ~full;
    word = (ERR_INJECT_AT != 0 && seq_q == WIDTH'(ERR_INJECT_AT)) ? seq_q ^ WIDTH'(1) : seq_q;
    seq_d = push ? seq_q + WIDTH'(1) : seq_q;
    pop = ~empty & (bp_q != BP_STALL);
    bp_d = bp_q + 2'd1;
    exp_d = pop ? exp_q + WIDTH'(1) : exp_q;
    cnt_d = (pop & ~&cnt_q) ? cnt_q + (WIDTH-1)'(1) : cnt_q;
    err_d = err_q | (pop & (fifo_data != exp_q));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seq_q <= WIDTH'(1);
      exp_q <= WIDTH'(1);
      bp_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      seq_q <= seq_d;
      exp_q <= exp_d;
      bp_q <= bp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign out = {err_q, cnt_q};
endmodule

// File: tb/tb_noc_sim_wrapper.sv
// tb_noc_sim_wrapper: directed checks of default, error-injecting and 8-bit instances
module tb_noc_sim_wrapper;
  logic clk = 1'b0, clk_n, rst = 1'b1;
  logic [31:0] out_def, out_err;
  logic [7:0] out_n8;
  int checks = 0, errors = 0;
  typedef struct {int cnt; logic err;} vec_t;
  vec_t tbl [12];
  assign clk_n = ~clk;
  always #5 clk = ~clk;
`ifdef DIFF_REFCLK
  noc_sim_wrapper u_def (.ref_clk_p(clk), .ref_clk_n(clk_n), .rst(rst), .out(out_def));
  noc_sim_wrapper #(.ERR_INJECT_AT(5)) u_err (.ref_clk_p(clk), .ref_clk_n(clk_n), .rst(rst), .out(out_err));
  noc_sim_wrapper #(.WIDTH(8)) u_n8 (.ref_clk_p(clk), .ref_clk_n(clk_n), .rst(rst), .out(out_n8));
`else
  noc_sim_wrapper u_def (.ref_clk(clk), .rst(rst), .out(out_def));
  noc_sim_wrapper #(.ERR_INJECT_AT(5)) u_err (.ref_clk(clk), .rst(rst), .out(out_err));
  noc_sim_wrapper #(.WIDTH(8)) u_n8 (.ref_clk(clk), .rst(rst), .out(out_n8));
`endif
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " def"}, out_def, 32'h0);
    chk({nm, " err"}, out_err, 32'h0);
    chk({nm, " n8"}, {24'h0, out_n8}, 32'h0);
  endtask
  task automatic run_table(input string nm);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s def e%0d", nm, i + 1), out_def, {1'b0, 31'(tbl[i].cnt)});
      chk($sformatf("%s err e%0d", nm, i + 1), out_err, {tbl[i].err, 31'(tbl[i].cnt)});
      chk($sformatf("%s n8 e%0d", nm, i + 1), {24'h0, out_n8}, 32'(tbl[i].cnt));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt_tbl [12] = '{0, 1, 2, 2, 3, 4, 5, 5, 6, 7, 8, 8};
    int model;
    for (int i = 0; i < 12; i++) tbl[i] = '{cnt_tbl[i], i >= 6};
    #2;
    chk_zero("reset");
    #8 rst = 1'b0;
    run_table("start");
    model = 8;
    for (int e = 13; e <= 1000; e++) begin
      @(posedge clk);
      if (e % 4 != 0) model++;
    end
    #1;
    chk("long def", out_def, {1'b0, 31'(model)});
    chk("long err", out_err, {1'b1, 31'(model)});
    chk("long n8 sat", {24'h0, out_n8}, 32'h7f);
    chk("long fifo full", {29'h0, u_def.u_fifo.count_q}, 32'd4);
    chk("long seq stall", u_def.seq_q, 32'(model + 5));
    #1 rst = 1'b1;
    #1 chk_zero("async rst");
    #2 rst = 1'b0;
    run_table("restart");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
